note_lane_renderer: RTL

// - Parametrised next-generation note-lane drawer. Per frame, walks NUM_SLOTS note slots and scans each
//   SQ_SIZE x SQ_SIZE square pixel by pixel, driving the VGA adapter's plot/x/y/colour inputs.
// - Colour per slot comes from the red/yellow note shifters. An ERASE mode paints every square black.
// - Adds a start/busy/done handshake so the game controller can sequence erase -> shift -> draw.

---
 rtl/note_lane_renderer_pkg.sv | 30 +++
 rtl/note_lane_renderer_square_scan.sv | 36 +++
 rtl/note_lane_renderer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/note_lane_renderer_pkg.sv
// Shared definitions for the lane/marker renderers: colours, screen bounds, FSM states.
package note_lane_renderer_pkg;

    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] BLUE   = 3'b001;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_FIN
    } lane_state_t;

    // Erase beats everything; red beats yellow; an empty slot is black.
    function automatic logic [2:0] slot_colour(input logic erase, input logic red, input logic yellow);
        if (erase)
            return BLACK;
        else if (red)
            return RED;
        else if (yellow)
            return YELLOW;
        return BLACK;
    endfunction

endpackage

// File: rtl/note_lane_renderer_square_scan.sv
// Raster walker for one SQ_SIZE x SQ_SIZE square: dx runs fastest, dy on dx wrap.
module square_scan #(
    parameter int unsigned SQ_SIZE = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear,
    input  logic       enable,
    output logic [2:0] dx,
    output logic [2:0] dy,
    output logic       last_pixel
);

    localparam logic [2:0] EDGE_MAX = 3'(SQ_SIZE - 1);

    assign last_pixel = (dx == EDGE_MAX) && (dy == EDGE_MAX);

    // Advance one pixel per enabled cycle; wraps back to (0,0) after the last pixel.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dx <= '0;
            dy <= '0;
        end else if (clear) begin
            dx <= '0;
            dy <= '0;
        end else if (enable) begin
            if (dx == EDGE_MAX) begin
                dx <= '0;
                dy <= (dy == EDGE_MAX) ? 3'd0 : dy + 3'd1;
            end else begin
                dx <= dx + 3'd1;
            end
        end
    end

endmodule

// File: rtl/note_lane_renderer.sv
// Note-lane drawer: walks NUM_SLOTS squares pixel by pixel into the VGA adapter,
// with a start/busy/done handshake for the game controller.
module note_lane_renderer
    import note_lane_renderer_pkg::*;
#(
    parameter int unsigned NUM_SLOTS  = 10,
    parameter int unsigned SQ_SIZE    = 4,
    parameter int unsigned X_ORIGIN   = 10,
    parameter int unsigned X_PITCH    = 10,
    parameter int unsigned Y_ROW      = 112,
    parameter int unsigned SKIP_EMPTY = 0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 erase,
    input  logic [NUM_SLOTS-1:0] red_seq,
    input  logic [NUM_SLOTS-1:0] yellow_seq,
    output logic                 busy,
    output logic                 done,
    output logic                 plot,
    output logic [7:0]           x,
    output logic [6:0]           y,
    output logic [2:0]           colour
);

    localparam int unsigned SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    if (X_ORIGIN + (NUM_SLOTS - 1) * X_PITCH + SQ_SIZE - 1 > SCREEN_W - 1) begin : g_x_range
        $error("note_lane_renderer: rightmost square exceeds screen width");
    end
    if (Y_ROW + SQ_SIZE - 1 > SCREEN_H - 1) begin : g_y_range
        $error("note_lane_renderer: square row exceeds screen height");
    end
    if (SQ_SIZE < 1 || SQ_SIZE > 8 || X_PITCH < SQ_SIZE) begin : g_sq_range
        $error("note_lane_renderer: SQ_SIZE must be 1..8 and X_PITCH >= SQ_SIZE");
    end

    lane_state_t          state_q, state_d;
    logic [SW-1:0]        slot_q, slot_d;
    logic [NUM_SLOTS-1:0] red_q, yellow_q;
    logic                 erase_q;
    logic [2:0]           dx, dy;
    logic                 last_pixel;
    logic                 accept, skip, last_slot, scan_en;
    logic                 busy_d, done_d, plot_d;
    logic [7:0]           x_d;
    logic [6:0]           y_d;
    logic [2:0]           colour_d;

    assign accept    = (state_q == S_IDLE) && start;
    assign last_slot = (slot_q == SW'(NUM_SLOTS - 1));
    assign skip      = (SKIP_EMPTY != 0) && !erase_q && !red_q[slot_q] && !yellow_q[slot_q];
    assign scan_en   = (state_q == S_SCAN) && !skip;

    square_scan #(.SQ_SIZE(SQ_SIZE)) u_scan (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (accept),
        .enable     (scan_en),
        .dx         (dx),
        .dy         (dy),
        .last_pixel (last_pixel)
    );

    // State register, latched pass inputs and registered VGA outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            slot_q   <= '0;
            red_q    <= '0;
            yellow_q <= '0;
            erase_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            plot     <= 1'b0;
            x        <= '0;
            y        <= '0;
            colour   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            if (accept) begin
                red_q    <= red_seq;
                yellow_q <= yellow_seq;
                erase_q  <= erase;
            end
            busy   <= busy_d;
            done   <= done_d;
            plot   <= plot_d;
            x      <= x_d;
            y      <= y_d;
            colour <= colour_d;
        end
    end

    // Next state, slot advance and next output values.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        plot_d   = 1'b0;
        x_d      = x;
        y_d      = y;
        colour_d = colour;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SCAN;
                    slot_d  = '0;
                end
            end
            S_SCAN: begin
                busy_d = 1'b1;
                if (!skip) begin
                    plot_d = 1'b1;
                    // 8-bit wrap-around sum equals the 9-bit sum truncated to 8 bits.
                    x_d      = 8'(X_ORIGIN) + 8'(slot_q) * 8'(X_PITCH) + 8'(dx);
                    y_d      = 7'(Y_ROW) + 7'(dy);
                    colour_d = slot_colour(erase_q, red_q[slot_q], yellow_q[slot_q]);
                end
                if (skip || last_pixel) begin
                    if (last_slot)
                        state_d = S_FIN;
                    else
                        slot_d = slot_q + SW'(1);
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
